soc_pfvf_tx_arb: RTL
====================

# soc_pfvf_tx_arb

Packet-level round-robin arbiter that merges the SoC PF/VF mux port streams (static-region PF0 port and the port-gasket shared VF port) into the single upstream AXI-S TX TLP stream toward the PCIe subsystem. It sits between the PF/VF routing mux ports and the host TX interface in the SoC AFU top. It guarantees whole-packet atomicity, fair per-packet rotation between ports, and a registered output stage that breaks the `tready` timing path.

## Interface
Parameters:
- `NUM_PORT`, 2, number of requesting mux ports (0 = SR PF0, 1 = PG shared VF); legal range 2..8.
- `DATA_W`, 512, TLP data width.
- `USER_W`, 10, tuser width, passed through unmodified.
- `PID_W`, `$clog2(NUM_PORT)`, width of port index.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_tvalid`  in  NUM_PORT  per-port valid.
- `in_tready`  out  NUM_PORT  per-port ready.
- `in_tdata`  in  NUM_PORT*DATA_W  per-port data; port p at [p*DATA_W +: DATA_W].
- `in_tkeep`  in  NUM_PORT*DATA_W/8  per-port byte keep.
- `in_tlast`  in  NUM_PORT  per-port end of packet.
- `in_tuser`  in  NUM_PORT*USER_W  per-port user.
- `out_tvalid`  out  1  merged valid.
- `out_tready`  in  1  merged ready.
- `out_tdata`, `out_tkeep`, `out_tlast`, `out_tuser`  out  DATA_W / DATA_W/8 / 1 / USER_W  merged beat.
- `out_pid`  out  PID_W  source port of the current output beat.
- `pkt_cnt`  out  NUM_PORT*16  per-port accepted-packet counters.

## Operation
- State machine, two states: IDLE (no packet in progress), LOCKED (packet from port `cur` in progress).
- Registers: `rr_ptr` (PID_W), `cur` (PID_W), output FIFO `cnt` (0..2), two-entry output FIFO.
- `space = (cnt < 2)`, computed from registered `cnt` only; no combinational path from `out_tready` to `in_tready`.
- IDLE: winner = first port p with `in_tvalid[p]`, searching p = rr_ptr, rr_ptr+1, ... modulo NUM_PORT. `in_tready[winner] = space`; all other ports ready 0. No valid port: all ready 0, state unchanged.
- IDLE with no transfer (space = 0): no state change; arbitration re-evaluated next cycle (winner may change, legal since no handshake occurred).
- IDLE accepted beat, tlast=0: go LOCKED, `cur` = winner.
- IDLE accepted beat, tlast=1 (single-beat packet): stay IDLE, `rr_ptr` = (winner+1) mod NUM_PORT.
- LOCKED: only `in_tready[cur] = space`; other ports' tvalid ignored. Accepted beat with tlast=1: go IDLE, `rr_ptr` = (cur+1) mod NUM_PORT.
- Accepted beat pushed into FIFO together with its source index (emitted on `out_pid`); tdata/tkeep/tlast/tuser unmodified.
- FIFO: push and pop in the same cycle leave `cnt` unchanged; data order preserved.
- `pkt_cnt[p]` increments on each accepted tlast beat from port p; 16-bit, wraps 0xFFFF -> 0x0000.

## Timing
- Reset values: `out_tvalid`=0, `in_tready`=0, `cnt`=0, state IDLE, `rr_ptr`=0, `cur`=0, all `pkt_cnt`=0, `out_pid`=0; data outputs don't-care.
- Latency: beat accepted at input in cycle N appears on output in cycle N+1 when the FIFO was empty.
- Throughput: one beat per cycle sustained with `out_tready` held high (cnt stays at 1).
- Backpressure: `out_tready` low for 2+ cycles fills FIFO; `in_tready` drops the cycle after `cnt` reaches 2 and rises the cycle after the first pop.
- Packet switch costs zero bubble: next packet's first beat may be accepted the cycle after the previous tlast.
- Reset mid-packet: FIFO contents and partial packet are dropped; arbiter restarts in IDLE with rr_ptr=0. The upstream source is reset alongside.
- `out_tvalid` never depends combinationally on any input.

## Test plan
- Single port: port 0 sends 3-beat packet, out_tready=1 -> 3 output beats cycles N+1..N+3, out_pid=0, pkt_cnt[0]=1.
- Contention: both ports hold valid 4-beat packets back-to-back, rr_ptr=0 -> output order P0,P1,P0,P1 by whole packet, no interleaved beats, no idle cycle between packets.
- Lock: port 1 starts 5-beat packet, port 0 asserts valid at beat 2 -> in_tready[0]=0 until port 1 tlast accepted; port 0 packet follows immediately.
- Backpressure: out_tready=0 for 6 cycles during stream -> exactly 2 beats buffered, in_tready low from cycle after cnt=2, no beat lost or duplicated after release.
- Single-beat packets from both ports every cycle -> strict alternation out_pid 0,1,0,1; pkt_cnt preloaded via 65536 packets on port 0 wraps to 0.
- Reset asserted mid-packet on beat 2 of 4 -> next cycle out_tvalid=0, in_tready=0, cnt=0, rr_ptr=0; new packet after reset forwarded correctly.

Source files
------------

// File: rtl/soc_pfvf_tx_arb.sv
// Packet-level round-robin merge of the PF/VF mux ports onto the single upstream TX TLP stream.
// Latency: one cycle from input handshake to output beat when the output buffer is empty.
// Backpressure: in_tready follows registered buffer occupancy only; out_tready never reaches in_tready combinationally.
module soc_pfvf_tx_arb #(
  parameter int NUM_PORT = 2,
  parameter int DATA_W   = 512,
  parameter int USER_W   = 10,
  parameter int PID_W    = $clog2(NUM_PORT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORT-1:0]            in_tvalid,
  output logic [NUM_PORT-1:0]            in_tready,
  input  logic [NUM_PORT*DATA_W-1:0]     in_tdata,
  input  logic [NUM_PORT*(DATA_W/8)-1:0] in_tkeep,
  input  logic [NUM_PORT-1:0]            in_tlast,
  input  logic [NUM_PORT*USER_W-1:0]     in_tuser,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic [DATA_W-1:0]              out_tdata,
  output logic [DATA_W/8-1:0]            out_tkeep,
  output logic                           out_tlast,
  output logic [USER_W-1:0]              out_tuser,
  output logic [PID_W-1:0]               out_pid,
  output logic [NUM_PORT*16-1:0]         pkt_cnt
);

  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t            state_q;
  logic [PID_W-1:0]  rr_ptr_q;
  logic [PID_W-1:0]  cur_q;

  // two-entry output buffer
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [DATA_W-1:0] dat_q  [2];
  logic [KEEP_W-1:0] keep_q [2];
  logic              last_q [2];
  logic [USER_W-1:0] user_q [2];
  logic [PID_W-1:0]  pid_q  [2];

  logic              space;
  logic              locked;
  logic              win_vld;
  logic [PID_W-1:0]  win_idx;
  logic [PID_W-1:0]  sel_idx;
  logic              sel_vld;
  logic              accept;
  logic              pop;
  logic [DATA_W-1:0] sel_dat;
  logic [KEEP_W-1:0] sel_keep;
  logic              sel_last;
  logic [USER_W-1:0] sel_user;
  logic [NUM_PORT*16-1:0] pkt_cnt_q;

  function automatic logic [PID_W-1:0] next_pid(input logic [PID_W-1:0] p);
    if (p == PID_W'(NUM_PORT - 1)) return '0;
    return p + PID_W'(1);
  endfunction

  // space depends only on registered occupancy so out_tready cannot ripple into in_tready
  assign space  = (cnt_q != 2'd2);
  assign locked = (state_q == ST_LOCKED);

  // round-robin search starting at rr_ptr, wrapping modulo NUM_PORT
  always_comb begin
    logic [PID_W:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      cand = {1'b0, rr_ptr_q} + (PID_W+1)'(i);
      if (cand >= (PID_W+1)'(NUM_PORT)) cand = cand - (PID_W+1)'(NUM_PORT);
      if (!win_vld && in_tvalid[cand[PID_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PID_W-1:0];
      end
    end
  end

  // a packet in progress owns the input until its tlast is accepted
  assign sel_idx = locked ? cur_q : win_idx;
  assign sel_vld = locked ? in_tvalid[cur_q] : win_vld;
  assign accept  = sel_vld & space;
  assign pop     = out_tvalid & out_tready;

  // ready only toward the selected port; nobody is ready in IDLE with no requester
  always_comb begin
    in_tready = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (space && (locked || win_vld) && (sel_idx == PID_W'(p))) in_tready[p] = 1'b1;
    end
  end

  // steer the selected port's beat toward the buffer write side
  always_comb begin
    sel_dat  = '0;
    sel_keep = '0;
    sel_last = 1'b0;
    sel_user = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (sel_idx == PID_W'(p)) begin
        sel_dat  = in_tdata[p*DATA_W +: DATA_W];
        sel_keep = in_tkeep[p*KEEP_W +: KEEP_W];
        sel_last = in_tlast[p];
        sel_user = in_tuser[p*USER_W +: USER_W];
      end
    end
  end

  // arbitration state: lock on a multi-beat packet, rotate priority after every tlast
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      cur_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (sel_last) begin
              rr_ptr_q <= next_pid(win_idx);
            end else begin
              state_q <= ST_LOCKED;
              cur_q   <= win_idx;
            end
          end
        end
        ST_LOCKED: begin
          if (accept && sel_last) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= next_pid(cur_q);
          end
        end
      endcase
    end
  end

  // occupancy next-state; simultaneous push and pop leaves it unchanged
  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // buffer pointers and occupancy; reset drops any buffered beats
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // payload storage needs no reset since it is only observed while out_tvalid is high
  always_ff @(posedge clk) begin
    if (accept) begin
      dat_q[wr_ptr_q]  <= sel_dat;
      keep_q[wr_ptr_q] <= sel_keep;
      last_q[wr_ptr_q] <= sel_last;
      user_q[wr_ptr_q] <= sel_user;
    end
  end

  // source index storage is reset so out_pid reads 0 out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pid_q[0] <= '0;
      pid_q[1] <= '0;
    end else if (accept) begin
      pid_q[wr_ptr_q] <= sel_idx;
    end
  end

  assign out_tvalid = (cnt_q != 2'd0);
  assign out_tdata  = dat_q[rd_ptr_q];
  assign out_tkeep  = keep_q[rd_ptr_q];
  assign out_tlast  = last_q[rd_ptr_q];
  assign out_tuser  = user_q[rd_ptr_q];
  assign out_pid    = pid_q[rd_ptr_q];

  // per-port packet counters, bumped on every accepted tlast and free-running through wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORT; p++) begin
        if (accept && sel_last && (sel_idx == PID_W'(p))) begin
          pkt_cnt_q[p*16 +: 16] <= pkt_cnt_q[p*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign pkt_cnt = pkt_cnt_q;

endmodule
